id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
ID/EX pipeline register that sits directly upstream of the ALU. It captures one decoded instruction from decode and resolves both source operands. Resolution uses x0 forcing, then EX/MEM forwarding, then MEM/WB forwarding, then register-file data. It applies the immediate/PC operand-select muxes and presents registered a, b and alu_ctrl to the ALU. It also detects load-use hazards (stalling decode), honours a flush from branch resolution, and counts stall cycles.

Parameters:
XLEN, 32, datapath width of operands, immediate, PC and forwarded results
STALL_CNT_W, 32, width of the saturating load-use stall counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage accepts the instruction this cycle
in_pc  input  XLEN  instruction PC
in_rs1_addr  input  5  source register 1 index
in_rs2_addr  input  5  source register 2 index
in_rs1_data  input  XLEN  register-file read data for rs1
in_rs2_data  input  XLEN  register-file read data for rs2
in_uses_rs1  input  1  instruction reads rs1
in_uses_rs2  input  1  instruction reads rs2
in_imm  input  XLEN  sign-extended immediate
in_alu_src_a  input  1  1: operand a = PC, 0: operand a = rs1
in_alu_src_b  input  1  1: operand b = imm, 0: operand b = rs2
in_alu_ctrl  input  4  ALU operation code, passed through
in_rd_addr  input  5  destination register
in_reg_write  input  1  instruction writes rd
in_mem_read  input  1  instruction is a load
in_mem_write  input  1  instruction is a store
exm_rd  input  5  EX/MEM destination register
exm_reg_write  input  1  EX/MEM writes rd
exm_mem_read  input  1  EX/MEM instruction is a load; its result is not yet available
exm_result  input  XLEN  EX/MEM ALU result
wb_rd  input  5  MEM/WB destination register
wb_reg_write  input  1  MEM/WB writes rd
wb_data  input  XLEN  MEM/WB writeback value
flush  input  1  kill the held instruction and any incoming one
out_valid  output  1  registered instruction valid toward the ALU
out_ready  input  1  EX accepts the held instruction
out_a  output  XLEN  ALU operand a
out_b  output  XLEN  ALU operand b
out_alu_ctrl  output  4  ALU operation code
out_store_data  output  XLEN  forwarded rs2 value, used for stores
out_rd_addr  output  5  destination register
out_reg_write  output  1  destination write enable
out_mem_read  output  1  load flag
out_mem_write  output  1  store flag
stall_count  output  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_n=0 at a rising edge): out_valid=0; all out_* data/control=0; stall_count=0. Reset overrides flush and capture. in_ready is combinational and is not forced by reset.
- Operand resolution, combinational on inputs, per source s in {rs1, rs2}, first match wins:
  - addr==0 -> 0
  - exm_reg_write & exm_rd==addr & ~exm_mem_read -> exm_result
  - wb_reg_write & wb_rd==addr -> wb_data
  - otherwise -> in_rsX_data
- Load-use hazard: hz = in_valid & exm_reg_write & exm_mem_read & exm_rd!=0 & ((in_uses_rs1 & exm_rd==in_rs1_addr) | (in_uses_rs2 & exm_rd==in_rs2_addr)).
- in_ready = (~out_valid | out_ready) & ~hz & ~flush.
- Operand muxes:
  - out_a <= in_alu_src_a ? in_pc : rs1_res
  - out_b <= in_alu_src_b ? in_imm : rs2_res
  - out_store_data <= rs2_res
- Per rising edge, priority order:
  1. Reset.
  2. flush: out_valid<=0. No capture; incoming instruction dropped.
  3. Capture when in_valid & in_ready: all out_* loaded, out_valid<=1. Latency is one cycle from acceptance to ALU inputs.
  4. Else if out_valid & out_ready: out_valid<=0 (bubble).
  5. Else hold all registers unchanged.
- Back-to-back: accept and drain in the same cycle is allowed, giving full throughput.
- Data/control outputs hold their last value when out_valid=0 and are don't-care for the consumer.
- stall_count increments by 1 in each cycle with hz & ~flush; it saturates at all-ones and is cleared only by reset.
- Flush during a hazard: the stall is not counted and the instruction is dropped.
- Forwarding with rd=x0 never overrides the x0 result.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_a=out_b=0, stall_count=0. Release; first accepted instruction appears one cycle later.
- Forwarding priority:
  - in_rs1_addr=5; exm_rd=5 (exm_result=0x11); wb_rd=5 (wb_data=0x22) -> out_a=0x11.
  - Drop exm_reg_write -> out_a=0x22.
  - Drop both -> out_a=in_rs1_data.
  - rs1_addr=0 with all forwards at rd=0 -> out_a=0.
- Load-use: exm_mem_read=1, exm_rd=7, in_rs2_addr=7, in_uses_rs2=1 -> in_ready=0 and stall_count +1 per cycle. Clear exm_mem_read and present wb_rd=7, wb_data=0xABCD -> capture with out_store_data=0xABCD.
- Operand select: in_alu_src_a=1, in_pc=0x100, in_alu_src_b=1, in_imm=0xFFFFFFFC, in_alu_ctrl=0000 -> out_a=0x100, out_b=0xFFFFFFFC, out_alu_ctrl=0000.
- Backpressure and flush:
  - out_ready=0 with out_valid=1 -> in_ready=0 and outputs stable for 3 cycles.
  - Assert flush -> out_valid=0 next cycle, incoming instruction discarded.
- Throughput: 4 back-to-back instructions with out_ready=1 -> 4 consecutive out_valid cycles, in order, no bubbles.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Purpose  : ID/EX pipeline register feeding the ALU. Resolves both source
//            operands (x0 forcing, EX/MEM forward, MEM/WB forward, register
//            file), applies the PC/immediate operand-select muxes, detects
//            load-use hazards, honours branch flush and counts stall cycles.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            in_*                  - decoded instruction and handshake from ID
//            exm_*, wb_*           - forwarding sources from EX/MEM and MEM/WB
//            flush                 - kill held and incoming instruction
//            out_*                 - registered instruction and handshake to EX
//            stall_count           - saturating load-use stall cycle count
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [4:0]             in_rs1_addr,
    input  logic [4:0]             in_rs2_addr,
    input  logic [XLEN-1:0]        in_rs1_data,
    input  logic [XLEN-1:0]        in_rs2_data,
    input  logic                   in_uses_rs1,
    input  logic                   in_uses_rs2,
    input  logic [XLEN-1:0]        in_imm,
    input  logic                   in_alu_src_a,
    input  logic                   in_alu_src_b,
    input  logic [3:0]             in_alu_ctrl,
    input  logic [4:0]             in_rd_addr,
    input  logic                   in_reg_write,
    input  logic                   in_mem_read,
    input  logic                   in_mem_write,
    input  logic [4:0]             exm_rd,
    input  logic                   exm_reg_write,
    input  logic                   exm_mem_read,
    input  logic [XLEN-1:0]        exm_result,
    input  logic [4:0]             wb_rd,
    input  logic                   wb_reg_write,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_a,
    output logic [XLEN-1:0]        out_b,
    output logic [3:0]             out_alu_ctrl,
    output logic [XLEN-1:0]        out_store_data,
    output logic [4:0]             out_rd_addr,
    output logic                   out_reg_write,
    output logic                   out_mem_read,
    output logic                   out_mem_write,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] c_stall_max = {STALL_CNT_W{1'b1}};

    logic                   r_valid;
    logic [XLEN-1:0]        r_a;
    logic [XLEN-1:0]        r_b;
    logic [3:0]             r_alu_ctrl;
    logic [XLEN-1:0]        r_store_data;
    logic [4:0]             r_rd_addr;
    logic                   r_reg_write;
    logic                   r_mem_read;
    logic                   r_mem_write;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [XLEN-1:0]        w_rs1_res;
    logic [XLEN-1:0]        w_rs2_res;
    logic                   w_hz;
    logic                   w_accept;

    // Operand resolution. A load sitting in EX/MEM has no result yet, so it
    // is skipped as a forwarding source; the hazard logic stalls instead.
    always_comb begin
        w_rs1_res = in_rs1_data;
        if (in_rs1_addr == 5'd0) begin
            w_rs1_res = '0;
        end else if (exm_reg_write && (exm_rd == in_rs1_addr) && !exm_mem_read) begin
            w_rs1_res = exm_result;
        end else if (wb_reg_write && (wb_rd == in_rs1_addr)) begin
            w_rs1_res = wb_data;
        end
    end

    always_comb begin
        w_rs2_res = in_rs2_data;
        if (in_rs2_addr == 5'd0) begin
            w_rs2_res = '0;
        end else if (exm_reg_write && (exm_rd == in_rs2_addr) && !exm_mem_read) begin
            w_rs2_res = exm_result;
        end else if (wb_reg_write && (wb_rd == in_rs2_addr)) begin
            w_rs2_res = wb_data;
        end
    end

    // Load-use: the consumer needs a value the load in EX/MEM has not produced.
    assign w_hz = in_valid && exm_reg_write && exm_mem_read && (exm_rd != 5'd0) &&
                  ((in_uses_rs1 && (exm_rd == in_rs1_addr)) ||
                   (in_uses_rs2 && (exm_rd == in_rs2_addr)));

    // Drain-and-accept in the same cycle is allowed for full throughput.
    assign in_ready = (!r_valid || out_ready) && !w_hz && !flush;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_alu_ctrl   <= '0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_a          <= in_alu_src_a ? in_pc  : w_rs1_res;
            r_b          <= in_alu_src_b ? in_imm : w_rs2_res;
            r_alu_ctrl   <= in_alu_ctrl;
            r_store_data <= w_rs2_res;
            r_rd_addr    <= in_rd_addr;
            r_reg_write  <= in_reg_write;
            r_mem_read   <= in_mem_read;
            r_mem_write  <= in_mem_write;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A flushed instruction never stalls, so its hazard cycle is not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hz && !flush && (r_stall_cnt != c_stall_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid      = r_valid;
    assign out_a          = r_a;
    assign out_b          = r_b;
    assign out_alu_ctrl   = r_alu_ctrl;
    assign out_store_data = r_store_data;
    assign out_rd_addr    = r_rd_addr;
    assign out_reg_write  = r_reg_write;
    assign out_mem_read   = r_mem_read;
    assign out_mem_write  = r_mem_write;
    assign stall_count    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_operand_stage
// Purpose  : Self-checking bench for id_ex_operand_stage. Directed scenarios
//            plus randomized traffic, compared each cycle against a
//            behavioural model of the stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

    localparam int XLEN = 32;
    localparam int SCW  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]      in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic            in_uses_rs1, in_uses_rs2, in_alu_src_a, in_alu_src_b;
    logic [3:0]      in_alu_ctrl;
    logic            in_reg_write, in_mem_read, in_mem_write;
    logic [4:0]      exm_rd, wb_rd;
    logic            exm_reg_write, exm_mem_read, wb_reg_write;
    logic [XLEN-1:0] exm_result, wb_data;
    logic            flush;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_a, out_b, out_store_data;
    logic [3:0]      out_alu_ctrl;
    logic [4:0]      out_rd_addr;
    logic            out_reg_write, out_mem_read, out_mem_write;
    logic [SCW-1:0]  stall_count;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.XLEN(XLEN), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_imm(in_imm),
        .in_alu_src_a(in_alu_src_a), .in_alu_src_b(in_alu_src_b),
        .in_alu_ctrl(in_alu_ctrl), .in_rd_addr(in_rd_addr),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write),
        .exm_mem_read(exm_mem_read), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_ctrl(out_alu_ctrl),
        .out_store_data(out_store_data), .out_rd_addr(out_rd_addr),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .stall_count(stall_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state: what EX should see after each edge.
    logic            m_known;
    logic            m_valid;
    logic [XLEN-1:0] m_a, m_b, m_sd;
    logic [3:0]      m_ctrl;
    logic [4:0]      m_rd;
    logic            m_rw, m_mr, m_mw;
    logic [SCW-1:0]  m_stall;

    // Value an instruction reading register 'addr' must see: x0 is zero,
    // otherwise the youngest in-flight writer with a ready value, else the RF.
    function automatic logic [XLEN-1:0] ref_operand(input logic [4:0] addr, input logic [XLEN-1:0] rf);
        logic [4:0]      src_rd  [2];
        logic            src_ok  [2];
        logic [XLEN-1:0] src_val [2];
        if (addr == 0) return '0;
        src_rd[0] = exm_rd; src_ok[0] = exm_reg_write && !exm_mem_read; src_val[0] = exm_result;
        src_rd[1] = wb_rd;  src_ok[1] = wb_reg_write;                   src_val[1] = wb_data;
        foreach (src_rd[k])
            if (src_ok[k] && src_rd[k] == addr) return src_val[k];
        return rf;
    endfunction

    function automatic logic ref_hazard();
        logic needs1, needs2;
        if (!in_valid || !exm_reg_write || !exm_mem_read || exm_rd == 0) return 1'b0;
        needs1 = in_uses_rs1 && in_rs1_addr == exm_rd;
        needs2 = in_uses_rs2 && in_rs2_addr == exm_rd;
        return needs1 || needs2;
    endfunction

    // One clock: check the combinational handshake, advance the model,
    // then compare every registered output just after the edge.
    task automatic cycle();
        logic hz, rdy;
        logic [XLEN-1:0] r1, r2;
        #1;
        hz  = ref_hazard();
        rdy = (!m_valid || out_ready) && !hz && !flush;
        if (rst_n && m_known) check_val("in_ready", in_ready, rdy);
        r1 = ref_operand(in_rs1_addr, in_rs1_data);
        r2 = ref_operand(in_rs2_addr, in_rs2_data);
        if (!rst_n) begin
            m_known = 1; m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_ctrl = 0;
            m_rd = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_stall = 0;
        end else begin
            if (hz && !flush && m_stall != '1) m_stall = m_stall + 1;
            if (flush) m_valid = 0;
            else if (in_valid && rdy) begin
                m_valid = 1;
                m_a    = in_alu_src_a ? in_pc : r1;
                m_b    = in_alu_src_b ? in_imm : r2;
                m_sd   = r2;
                m_ctrl = in_alu_ctrl; m_rd = in_rd_addr;
                m_rw = in_reg_write; m_mr = in_mem_read; m_mw = in_mem_write;
            end else if (m_valid && out_ready) m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_val("out_valid", out_valid, m_valid);
        check_val("out_a", out_a, m_a);
        check_val("out_b", out_b, m_b);
        check_val("out_store_data", out_store_data, m_sd);
        check_val("out_ctrl", {out_alu_ctrl, out_rd_addr, out_reg_write, out_mem_read, out_mem_write},
                  {m_ctrl, m_rd, m_rw, m_mr, m_mw});
        check_val("stall_count", stall_count, m_stall);
    endtask

    task automatic set_idle();
        in_valid = 0; in_pc = 0; in_rs1_addr = 0; in_rs2_addr = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_uses_rs1 = 0; in_uses_rs2 = 0;
        in_imm = 0; in_alu_src_a = 0; in_alu_src_b = 0; in_alu_ctrl = 0;
        in_rd_addr = 0; in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
        exm_rd = 0; exm_reg_write = 0; exm_mem_read = 0; exm_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [XLEN-1:0] held_a;
        logic [SCW-1:0]  s0;
        m_known = 0; m_valid = 0;
        set_idle();

        // Reset with a valid instruction pending
        rst_n = 0; in_valid = 1; in_rs1_addr = 3; in_rs1_data = 32'h1234; in_uses_rs1 = 1;
        cycle(); cycle();
        check_val("rst_valid", out_valid, 0);
        check_val("rst_a_b", {out_a, out_b}, 64'd0);
        check_val("rst_stall", stall_count, 0);

        // Forwarding priority on rs1
        rst_n = 1;
        in_rs1_addr = 5; in_rs1_data = 32'h33;
        exm_rd = 5; exm_reg_write = 1; exm_result = 32'h11;
        wb_rd = 5; wb_reg_write = 1; wb_data = 32'h22;
        cycle();
        check_val("first_valid", out_valid, 1);
        check_val("fwd_exm", out_a, 32'h11);
        exm_reg_write = 0; cycle();
        check_val("fwd_wb", out_a, 32'h22);
        wb_reg_write = 0; cycle();
        check_val("fwd_rf", out_a, 32'h33);
        in_rs1_addr = 0; exm_rd = 0; wb_rd = 0; exm_reg_write = 1; wb_reg_write = 1;
        cycle();
        check_val("x0_forced", out_a, 0);

        // Load-use stall then forward from MEM/WB
        set_idle();
        in_valid = 1; in_rs2_addr = 7; in_uses_rs2 = 1; in_rs2_data = 32'h5555;
        exm_rd = 7; exm_reg_write = 1; exm_mem_read = 1;
        s0 = stall_count;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("hz_not_ready", in_ready, 0);
        end
        check_val("stall_plus3", stall_count, s0 + 3);
        exm_mem_read = 0; exm_reg_write = 0; wb_rd = 7; wb_reg_write = 1; wb_data = 32'hABCD;
        cycle();
        check_val("lu_store_data", out_store_data, 32'hABCD);

        // Operand select
        set_idle();
        in_valid = 1; in_alu_src_a = 1; in_pc = 32'h100; in_alu_src_b = 1;
        in_imm = 32'hFFFF_FFFC; in_alu_ctrl = 4'b0000; in_rs1_addr = 2; in_rs1_data = 9;
        cycle();
        check_val("sel_a", out_a, 32'h100);
        check_val("sel_b", out_b, 32'hFFFF_FFFC);
        check_val("sel_ctrl", out_alu_ctrl, 0);

        // Backpressure: held instruction stays put
        held_a = out_a;
        out_ready = 0; in_pc = 32'h999; in_alu_ctrl = 4'd5;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("bp_not_ready", in_ready, 0);
            check_val("bp_stable", out_a, held_a);
        end
        flush = 1; cycle();
        check_val("flush_valid", out_valid, 0);
        flush = 0; in_valid = 0; cycle();
        check_val("flush_dropped", out_valid, 0);

        // Flush during a hazard is not counted
        set_idle();
        in_valid = 1; in_rs1_addr = 4; in_uses_rs1 = 1; exm_rd = 4; exm_reg_write = 1;
        exm_mem_read = 1; flush = 1;
        s0 = stall_count;
        cycle();
        check_val("flush_hz_nocount", stall_count, s0);

        // Throughput: four back-to-back instructions
        set_idle();
        in_valid = 1; in_alu_src_a = 1;
        for (int i = 0; i < 4; i++) begin
            in_pc = 32'h200 + 32'(4 * i);
            cycle();
            check_val("tput_valid", out_valid, 1);
            check_val("tput_order", out_a, 32'h200 + 32'(4 * i));
        end
        in_valid = 0; cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_pc         = $urandom; in_imm = $urandom;
            in_rs1_addr   = 5'($urandom_range(0, 7));
            in_rs2_addr   = 5'($urandom_range(0, 7));
            in_rs1_data   = $urandom; in_rs2_data = $urandom;
            in_uses_rs1   = 1'($urandom); in_uses_rs2 = 1'($urandom);
            in_alu_src_a  = 1'($urandom); in_alu_src_b = 1'($urandom);
            in_alu_ctrl   = 4'($urandom); in_rd_addr = 5'($urandom);
            in_reg_write  = 1'($urandom); in_mem_read = 1'($urandom);
            in_mem_write  = 1'($urandom);
            exm_rd        = 5'($urandom_range(0, 7));
            exm_reg_write = 1'($urandom);
            exm_mem_read  = ($urandom_range(0, 3) == 0);
            exm_result    = $urandom;
            wb_rd         = 5'($urandom_range(0, 7));
            wb_reg_write  = 1'($urandom);
            wb_data       = $urandom;
            flush         = ($urandom_range(0, 9) == 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
